// File: rtl/branch_predict_ctrl_if.sv
// Fetch/execute signal bundle for the branch predictor. The core (master) drives the
// fetch PC and execute-stage resolution inputs; the predictor (slave) returns prediction,
// redirect, flush and performance outputs.
interface branch_predict_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    // No valid/ready handshake: every signal is sampled each cycle, and pipeline
    // occupancy is governed only by StallD and the flush outputs.
    logic [ADDR_W-1:0] PCF;
    logic              StallD;
    logic              BranchE;
    logic              CondExE;
    logic [ADDR_W-1:0] BranchTgtE;
    logic [ADDR_W-1:0] PCPlus4E;
    logic              PredTakenF;
    logic [ADDR_W-1:0] PredTgtF;
    logic              MispredictE;
    logic [ADDR_W-1:0] RedirectPCE;
    logic              FlushD;
    logic              FlushE;
    logic [CNT_W-1:0]  BrCount;
    logic [CNT_W-1:0]  MissCount;
    logic [1:0]        DbgCtrF;

    modport master (
        output PCF, StallD, BranchE, CondExE, BranchTgtE, PCPlus4E,
        input  PredTakenF, PredTgtF, MispredictE, RedirectPCE, FlushD, FlushE,
        input  BrCount, MissCount, DbgCtrF
    );

    modport slave (
        input  PCF, StallD, BranchE, CondExE, BranchTgtE, PCPlus4E,
        output PredTakenF, PredTgtF, MispredictE, RedirectPCE, FlushD, FlushE,
        output BrCount, MissCount, DbgCtrF
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB with 2-bit saturating counters, F->D->E prediction pipe,
// execute-stage mispredict detection/redirect, and saturating perf counters.
module branch_predict_ctrl #(
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predict_ctrl_if.slave bus
);
    localparam int N     = 2 ** IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [1:0] {SN = 2'b00, WN = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;

    typedef struct packed {
        logic              vld;
        logic              pred;
        logic [ADDR_W-1:0] tgt;
        logic [IDX_W-1:0]  idx;
        logic [TAG_W-1:0]  tag;
    } pipe_t;

    logic              valid_q [N];
    logic [TAG_W-1:0]  tag_q   [N];
    logic [ADDR_W-1:0] tgt_q   [N];
    ctr_e              ctr_q   [N];
    ctr_e              ctr_d;

    pipe_t d_q, d_d, e_q, e_d, f_info;

    logic [IDX_W-1:0]  idx_f;
    logic [TAG_W-1:0]  tag_f;
    logic              hit_f, pred_f;
    logic [ADDR_W-1:0] tgt_f;
    logic              taken, resolve, hit_e, upd_hit, alloc;
    logic              mispredict, flush_e;
    logic [ADDR_W-1:0] redirect;
    logic [CNT_W-1:0]  br_q, miss_q;

    // Fetch lookup reads the table state before any same-cycle update lands.
    always_comb begin
        idx_f  = bus.PCF[IDX_W+1:2];
        tag_f  = bus.PCF[ADDR_W-1:IDX_W+2];
        hit_f  = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        pred_f = hit_f && ctr_q[idx_f][1];
        tgt_f  = pred_f ? tgt_q[idx_f] : '0;
        f_info = '{vld: 1'b1, pred: pred_f, tgt: tgt_f, idx: idx_f, tag: tag_f};
    end

    always_comb begin
        taken      = bus.CondExE;
        resolve    = e_q.vld && bus.BranchE;
        hit_e      = valid_q[e_q.idx] && (tag_q[e_q.idx] == e_q.tag);
        upd_hit    = resolve && hit_e;
        alloc      = resolve && !hit_e && taken;
        mispredict = 1'b0;
        redirect   = '0;
        if (resolve) begin
            mispredict = (taken != e_q.pred) ||
                         (taken && e_q.pred && (bus.BranchTgtE != e_q.tgt));
            redirect   = taken ? bus.BranchTgtE : bus.PCPlus4E;
        end
        flush_e = mispredict || bus.StallD;
    end

    // Counter FSM next state for the entry being resolved in E.
    always_comb begin
        ctr_d = ctr_q[e_q.idx];
        if (taken) begin
            unique case (ctr_q[e_q.idx])
                SN:      ctr_d = WN;
                WN:      ctr_d = WT;
                default: ctr_d = ST;
            endcase
        end else begin
            unique case (ctr_q[e_q.idx])
                ST:      ctr_d = WT;
                WT:      ctr_d = WN;
                default: ctr_d = SN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= WN;
            end
        end else if (upd_hit) begin
            ctr_q[e_q.idx] <= ctr_d;
            if (taken) tgt_q[e_q.idx] <= bus.BranchTgtE;
        end else if (alloc) begin
            valid_q[e_q.idx] <= 1'b1;
            tag_q[e_q.idx]   <= e_q.tag;
            tgt_q[e_q.idx]   <= bus.BranchTgtE;
            ctr_q[e_q.idx]   <= WT;
        end
    end

    // A mispredict flush wins over StallD: D is cleared rather than held.
    always_comb begin
        d_d = d_q;
        if (mispredict)       d_d.vld = 1'b0;
        else if (!bus.StallD) d_d = f_info;
        e_d = d_q;
        if (flush_e) e_d.vld = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_q <= '0;
            e_q <= '0;
        end else begin
            d_q <= d_d;
            e_q <= e_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_q   <= '0;
            miss_q <= '0;
        end else begin
            if (resolve && (br_q != '1))      br_q   <= br_q + CNT_W'(1);
            if (mispredict && (miss_q != '1)) miss_q <= miss_q + CNT_W'(1);
        end
    end

    always_comb begin
        bus.PredTakenF  = pred_f;
        bus.PredTgtF    = tgt_f;
        bus.MispredictE = mispredict;
        bus.RedirectPCE = redirect;
        bus.FlushD      = mispredict;
        bus.FlushE      = flush_e;
        bus.BrCount     = br_q;
        bus.MissCount   = miss_q;
        bus.DbgCtrF     = ctr_q[idx_f];
    end
endmodule
